// File: rtl/pwm_seq_ctrl.sv
// Four-channel PWM sequencer: shared up-counter with programmable period,
// per-channel compare thresholds, shadow registers committed at the wrap.
// Ports:
//   clock, reset            core clock, async active-high reset
//   cfg_valid/cfg_ready     config write handshake
//   cfg_addr, cfg_wdata     0=CTRL 1=PERIOD 2..5=CMP0..3 6=IP_CLR 7=reserved
//   io_pwm_port[3:0]        registered PWM levels
//   io_ip[3:0]              sticky compare-match flags
//   io_count, io_running    current counter value and sequencer activity
module pwm_seq_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic [3:0]       io_pwm_port,
  output logic [3:0]       io_ip,
  output logic [CNT_W-1:0] io_count,
  output logic             io_running
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned CLR_W = (CNT_W < NCH) ? CNT_W : NCH;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       ctrl_sh;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] cmp_sh  [NCH];
  logic             oneshot_act;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] cmp_act [NCH];
  logic [CNT_W-1:0] count;

  logic             running;
  logic             wrap;
  logic             wr;
  logic             load_act;
  logic [NCH-1:0]   clr_mask;
  logic [NCH-1:0]   ip_set;

  assign running  = (state == ST_RUN);
  assign wrap     = (count == period_act);
  assign wr       = cfg_valid && cfg_ready;
  // Active set tracks shadow while idle and commits only at the wrap.
  assign load_act = !running || wrap;
  assign clr_mask = (wr && cfg_addr == 3'd6) ? NCH'(cfg_wdata[CLR_W-1:0]) : '0;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ip_set[i] = running && (cmp_act[i] != '0) &&
                  (count == cmp_act[i] - CNT_W'(1));
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a stop or oneshot always completes the current period
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ctrl_sh[0]) state_nxt = ST_RUN;
      ST_RUN:  if (wrap && (!ctrl_sh[0] || oneshot_act)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: writes are blocked on the commit cycle only
  always_comb begin
    cfg_ready = 1'b1;
    if (running && wrap) cfg_ready = 1'b0;
  end

  // Shadow registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_sh   <= '0;
      period_sh <= '0;
      for (int i = 0; i < NCH; i++) cmp_sh[i] <= '0;
    end else begin
      if (wr) begin
        case (cfg_addr)
          3'd0:    ctrl_sh   <= cfg_wdata[1:0];
          3'd1:    period_sh <= cfg_wdata;
          3'd2:    cmp_sh[0] <= cfg_wdata;
          3'd3:    cmp_sh[1] <= cfg_wdata;
          3'd4:    cmp_sh[2] <= cfg_wdata;
          3'd5:    cmp_sh[3] <= cfg_wdata;
          default: ;
        endcase
      end
      // Oneshot drops EN at its wrap so no second period starts
      if (running && wrap && oneshot_act) ctrl_sh[0] <= 1'b0;
    end
  end

  // Active registers and counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oneshot_act <= 1'b0;
      period_act  <= '0;
      for (int i = 0; i < NCH; i++) cmp_act[i] <= '0;
      count       <= '0;
    end else begin
      if (load_act) begin
        oneshot_act <= ctrl_sh[1];
        period_act  <= period_sh;
        for (int i = 0; i < NCH; i++) cmp_act[i] <= cmp_sh[i];
        count       <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Registered PWM levels and sticky flags (set beats clear)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_pwm_port <= '0;
      io_ip       <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        io_pwm_port[i] <= running && (count < cmp_act[i]);
      end
      io_ip <= (io_ip & ~clr_mask) | ip_set;
    end
  end

  assign io_count   = count;
  assign io_running = running;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
module tb_pwm_seq_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clock;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic [3:0]       io_pwm_port;
  logic [3:0]       io_ip;
  logic [CNT_W-1:0] io_count;
  logic             io_running;

  int n_cmp;
  int n_bad;

  pwm_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .io_pwm_port (io_pwm_port),
    .io_ip       (io_ip),
    .io_count    (io_count),
    .io_running  (io_running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Call while the clock is low; holds the request until accepted.
  task automatic cfg_write(input logic [2:0] a, input logic [CNT_W-1:0] d, output int stalls);
    stalls    = 0;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    while (!cfg_ready && stalls < 20) begin
      stalls++;
      @(negedge clock);
    end
    if (!cfg_ready) begin
      check("wr_timeout", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      cfg_valid = 1'b0;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [CNT_W-1:0] d);
    int s;
    @(negedge clock);
    cfg_write(a, d, s);
  endtask

  task automatic wait_count(input int v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (int'(io_count) == v) break;
    end
    if (int'(io_count) != v) check("wait_count", 32'(io_count), 32'(v));
  endtask

  // CTRL=3 with PERIOD=4, CMP0=2 already in shadow: one 2-cycle pulse.
  task automatic oneshot_run();
    int pulses;
    bit exp_run;
    pulses = 0;
    wr(3'd0, 16'd3);
    for (int n = 0; n <= 12; n++) begin
      @(negedge clock);
      exp_run = (n >= 1 && n <= 5);
      check("os_running", 32'(io_running), 32'(exp_run));
      check("os_count", 32'(io_count), exp_run ? 32'(n - 1) : 32'd0);
      check("os_pwm0", 32'(io_pwm_port[0]), 32'((n == 2) || (n == 3)));
      if (n == 5) check("os_ready_wrap", 32'(cfg_ready), 32'd0);
      if (io_pwm_port[0]) pulses++;
    end
    check("os_pulse_len", 32'(pulses), 32'd2);
  endtask

  initial begin
    int s;
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_pwm", 32'(io_pwm_port), 32'd0);
    check("rst_ip", 32'(io_ip), 32'd0);
    check("rst_count", 32'(io_count), 32'd0);
    check("rst_running", 32'(io_running), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;

    // Basic run: PERIOD=9, CMP0=3 -> 3 high / 7 low
    wr(3'd1, 16'd9);
    wr(3'd2, 16'd3);
    wr(3'd0, 16'd1);
    @(negedge clock);
    check("run_delay", 32'(io_running), 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check("b_running", 32'(io_running), 32'd1);
      check("b_count", 32'(io_count), 32'(k % 10));
      check("b_pwm0", 32'(io_pwm_port[0]), 32'(k >= 1 && ((k - 1) % 10) < 3));
      check("b_ready", 32'(cfg_ready), 32'((k % 10) != 9));
    end

    // Mid-period CMP0=7 takes effect only after the next wrap
    wr(3'd2, 16'd7);
    for (int m = 1; m <= 20; m++) begin
      @(negedge clock);
      check("sc_count", 32'(io_count), 32'(m % 10));
      check("sc_pwm0", 32'(io_pwm_port[0]), 32'(((m - 1) % 10) < ((m <= 10) ? 3 : 7)));
    end

    // Write held across the wrap cycle lands on the following cycle
    wait_count(9);
    check("ready_at_wrap", 32'(cfg_ready), 32'd0);
    cfg_write(3'd3, 16'd0, s);
    check("held_stalls", 32'(s), 32'd1);
    @(negedge clock);
    check("held_land", 32'(io_count), 32'd1);

    // Edge duties: CMP1=0, CMP2=10, CMP3=20
    wr(3'd4, 16'd10);
    wr(3'd5, 16'd20);
    wait_count(9);
    wait_count(1);
    for (int i = 0; i < 20; i++) begin
      check("edge_pwm31", 32'(io_pwm_port[3:1]), 32'b110);
      check("edge_ip1", 32'(io_ip[1]), 32'd0);
      check("edge_ip3", 32'(io_ip[3]), 32'd0);
      @(negedge clock);
    end

    // IP flags with CMP0=3: set on count==2, clear, set-wins collision
    wr(3'd2, 16'd3);
    wait_count(9);
    wait_count(5);
    check("ip0_before_clr", 32'(io_ip[0]), 32'd1);
    cfg_write(3'd6, 16'h0001, s);
    @(negedge clock);
    check("ip0_cleared", 32'(io_ip[0]), 32'd0);
    wait_count(2);
    check("ip0_pre_set", 32'(io_ip[0]), 32'd0);
    @(negedge clock);
    check("ip0_set_cnt", 32'(io_count), 32'd3);
    check("ip0_set", 32'(io_ip[0]), 32'd1);
    wait_count(2);
    cfg_write(3'd6, 16'h0001, s);
    @(negedge clock);
    check("ip0_set_wins", 32'(io_ip[0]), 32'd1);

    // Stop with EN=0 completes the period then idles
    wr(3'd0, 16'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (!io_running) break;
    end
    check("stop_running", 32'(io_running), 32'd0);
    check("stop_count", 32'(io_count), 32'd0);
    @(negedge clock);
    check("stop_pwm", 32'(io_pwm_port), 32'd0);

    // Oneshot twice
    wr(3'd1, 16'd4);
    wr(3'd2, 16'd2);
    oneshot_run();
    oneshot_run();

    // Async reset mid-period with ch0 high
    wr(3'd1, 16'd9);
    wr(3'd2, 16'd7);
    wr(3'd0, 16'd1);
    wait_count(5);
    check("pre_rst_pwm0", 32'(io_pwm_port[0]), 32'd1);
    check("pre_rst_running", 32'(io_running), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_pwm", 32'(io_pwm_port), 32'd0);
    check("arst_count", 32'(io_count), 32'd0);
    check("arst_running", 32'(io_running), 32'd0);
    check("arst_ip", 32'(io_ip), 32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("post_rst_running", 32'(io_running), 32'd0);
      check("post_rst_count", 32'(io_count), 32'd0);
    end
    wr(3'd0, 16'd1);
    @(negedge clock);
    check("restart_delay", 32'(io_running), 32'd0);
    @(negedge clock);
    check("restart_running", 32'(io_running), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
